// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR   = 11;

    function automatic int cpb(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search starting one past the last granted client.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate down so the nearest one to last+1 wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; paces frames by a computed frame time plus guard.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int GUARD_CYCLES = 16,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [1:0]           parity_sel,
    output logic [NUM_REQ-1:0]   ack,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    output logic [1:0]           tx_parity_type
);

    localparam int          CPB      = cpb(CLK_FREQ, BAUD);
    localparam logic [31:0] N_NOPAR  = 32'(FRAME_BITS_NOPAR * CPB + GUARD_CYCLES);
    localparam logic [31:0] N_PAR    = 32'(FRAME_BITS_PAR * CPB + GUARD_CYCLES);

    state_t                    state;
    logic [31:0]               cnt;
    logic [IDX_W-1:0]          last;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;
    logic [NUM_REQ-1:0][7:0]   req_bytes;
    logic [31:0]               cnt_last;

    assign req_bytes = req_data;
    assign busy      = (state != ST_IDLE);
    assign cnt_last  = (tx_parity_type == PAR_NONE) ? N_NOPAR - 32'd1 : N_PAR - 32'd1;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            last           <= IDX_W'(NUM_REQ - 1);
            ack            <= '0;
            grant_id       <= '0;
            tx_data        <= '0;
            tx_send        <= 1'b0;
            tx_parity_type <= PAR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        tx_data        <= req_bytes[pick_idx];
                        tx_parity_type <= (parity_sel == 2'd3) ? PAR_NONE : parity_sel;
                        grant_id       <= pick_idx;
                        tx_send        <= 1'b1;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_send <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_WAIT;
                end
                // transmitter has no done flag, so the frame is timed out here
                ST_WAIT: begin
                    if (cnt == cnt_last) begin
                        ack   <= NUM_REQ'(1) << grant_id;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    ack   <= '0;
                    last  <= grant_id;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected send/ack events, a negedge monitor checks them.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [8*NR-1:0] req_data;
    logic [1:0]    parity_sel;
    logic [NR-1:0] ack;
    logic [1:0]    grant_id;
    logic          busy;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic [1:0]    tx_parity_type;

    typedef struct {int cyc; logic [1:0] id; logic [7:0] data; logic [1:0] par;} send_t;
    typedef struct {int cyc; logic [NR-1:0] ackv; logic [7:0] data; logic [1:0] par;} ack_t;

    send_t send_q[$];
    ack_t  ack_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  prev_send = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NR), .CLK_FREQ(1000), .BAUD(100), .GUARD_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .parity_sel     (parity_sel),
        .ack            (ack),
        .grant_id       (grant_id),
        .busy           (busy),
        .tx_data        (tx_data),
        .tx_send        (tx_send),
        .tx_parity_type (tx_parity_type)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Clients release their request on seeing their ack.
    always @(negedge clk) if (!rst) req = req & ~ack;

    // Monitor
    always @(negedge clk) begin
        if (tx_send) begin
            send_t e;
            checks++;
            if (prev_send) begin
                errors++;
                $display("FAIL send_twice cyc=%0d tx_send high on consecutive cycles", cyc);
            end
            checks++;
            if (send_q.size() == 0) begin
                errors++;
                $display("FAIL send_unexpected cyc=%0d got id=%0d data=%h", cyc, grant_id, tx_data);
            end else begin
                e = send_q.pop_front();
                if (e.cyc != cyc || e.id != grant_id || e.data != tx_data || e.par != tx_parity_type) begin
                    errors++;
                    $display("FAIL send cyc/id/data/par got %0d/%0d/%h/%0d want %0d/%0d/%h/%0d",
                             cyc, grant_id, tx_data, tx_parity_type, e.cyc, e.id, e.data, e.par);
                end
            end
        end
        if (ack != '0) begin
            ack_t a;
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected cyc=%0d got ack=%b", cyc, ack);
            end else begin
                a = ack_q.pop_front();
                if (a.cyc != cyc || a.ackv != ack || a.data != tx_data || a.par != tx_parity_type) begin
                    errors++;
                    $display("FAIL ack cyc/ack/data/par got %0d/%b/%h/%0d want %0d/%b/%h/%0d",
                             cyc, ack, tx_data, tx_parity_type, a.cyc, a.ackv, a.data, a.par);
                end
            end
        end
        prev_send = tx_send;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_send(input int c, input logic [1:0] id, input logic [7:0] d, input logic [1:0] p);
        send_t e;
        e.cyc = c; e.id = id; e.data = d; e.par = p;
        send_q.push_back(e);
    endtask

    task automatic exp_ack(input int c, input logic [1:0] id, input logic [7:0] d, input logic [1:0] p);
        ack_t a;
        a.cyc = c; a.ackv = NR'(1) << id; a.data = d; a.par = p;
        ack_q.push_back(a);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || ack !== '0 || tx_send !== 1'b0 || tx_data !== 8'h00 ||
            grant_id !== 2'd0 || tx_parity_type !== 2'd0) begin
            errors++;
            $display("FAIL %s busy/ack/send/data/gid/par got %b/%b/%b/%h/%0d/%0d want 0/0000/0/00/0/0",
                     name, busy, ack, tx_send, tx_data, grant_id, tx_parity_type);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        parity_sel = 2'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int b = 0;
        while ((send_q.size() != 0 || ack_q.size() != 0) && b < 1000) begin
            next_cycle();
            b++;
        end
        checks++;
        if (send_q.size() != 0 || ack_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending send=%0d ack=%0d want 0/0", name, send_q.size(), ack_q.size());
        end
    endtask

    initial begin
        int k;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        do_reset();
        check_idle("reset_state");

        // 1: single request
        req_data[7:0] = 8'hA5;
        k = cyc;
        req = 4'b0001;
        exp_send(k + 1, 2'd0, 8'hA5, 2'd0);
        exp_ack(k + 106, 2'd0, 8'hA5, 2'd0);
        drain("t1");

        // 2: all four, grant order 0..3, period 107
        do_reset();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        k = cyc;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_send(k + 1 + 107 * i, 2'(i), 8'h10 + 8'(i * 17), 2'd0);
            exp_ack(k + 106 + 107 * i, 2'(i), 8'h10 + 8'(i * 17), 2'd0);
        end
        drain("t2");

        // 3: client 2 re-requests right after its ack; 3 must go first
        do_reset();
        k = cyc;
        req = 4'b1100;
        exp_send(k + 1, 2'd2, 8'h32, 2'd0);
        exp_ack(k + 106, 2'd2, 8'h32, 2'd0);
        exp_send(k + 108, 2'd3, 8'h43, 2'd0);
        exp_ack(k + 213, 2'd3, 8'h43, 2'd0);
        exp_send(k + 215, 2'd2, 8'h32, 2'd0);
        exp_ack(k + 320, 2'd2, 8'h32, 2'd0);
        while (cyc < k + 107) next_cycle();
        req[2] = 1'b1;
        drain("t3");

        // 4: odd parity frame, then parity_sel=3 maps to none
        do_reset();
        req_data[7:0] = 8'h07;
        parity_sel = 2'd1;
        k = cyc;
        req = 4'b0001;
        exp_send(k + 1, 2'd0, 8'h07, 2'd1);
        exp_ack(k + 116, 2'd0, 8'h07, 2'd1);
        drain("t4a");
        k = cyc;
        parity_sel = 2'd3;
        req = 4'b0001;
        exp_send(k + 1, 2'd0, 8'h07, 2'd0);
        exp_ack(k + 106, 2'd0, 8'h07, 2'd0);
        drain("t4b");

        // 5: reset mid-WAIT, re-grant one cycle after release
        do_reset();
        req_data[7:0] = 8'h5A;
        k = cyc;
        req = 4'b0001;
        exp_send(k + 1, 2'd0, 8'h5A, 2'd0);
        while (cyc < k + 50) next_cycle();
        rst = 1'b1;
        next_cycle();
        check_idle("rst_mid_wait");
        next_cycle();
        next_cycle();
        rst = 1'b0;
        k = cyc;
        exp_send(k + 1, 2'd0, 8'h5A, 2'd0);
        exp_ack(k + 106, 2'd0, 8'h5A, 2'd0);
        drain("t5");

        // 6: request dropped during WAIT still gets ack
        do_reset();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        k = cyc;
        req = 4'b0010;
        exp_send(k + 1, 2'd1, 8'h21, 2'd0);
        exp_ack(k + 106, 2'd1, 8'h21, 2'd0);
        while (cyc < k + 30) next_cycle();
        req = 4'b0000;
        drain("t6");

        repeat (5) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `transmitter` UART instance among `NUM_REQ` byte-producing clients. It grants one client at a time, latches that client's byte and parity mode, issues a single-cycle `send_data` pulse, and holds `tx_data` stable for the whole frame. It then waits a computed frame time plus a guard interval, since `transmitter` has no busy/done output, and acknowledges the client. It sits between the client logic and `transmitter` in the UART top level.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLK_FREQ`, 50_000_000: clock frequency, Hz.
- `BAUD`, 115_200: line rate. `CPB = CLK_FREQ / BAUD` uses integer division, which gives 434 at the defaults.
- `GUARD_CYCLES`, 16: idle cycles appended after each frame. Minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request per client. Held with its byte until `ack`.
- `req_data`  in  8*NUM_REQ  client i byte at bits [8i+7:8i].
- `parity_sel`  in  2  0 none, 1 odd, 2 even, 3 treated as 0. Sampled at grant.
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse: frame for that client complete.
- `grant_id`  out  $clog2(NUM_REQ)  index of current or last grant.
- `busy`  out  1  high whenever state is not IDLE.
- `tx_data`  out  8  to `transmitter.data`.
- `tx_send`  out  1  to `transmitter.send_data`.
- `tx_parity_type`  out  2  to `transmitter.parity_type`.

## Operation
- States: IDLE, SEND, WAIT, DONE.
- **IDLE:** if `|req` is true, pick the first asserted requester searching from `last+1` with wrap-around. Latch `req_data` slice into `tx_data`, latch `parity_sel` (mapping 3 to 0) into `tx_parity_type`, set `grant_id`, go to SEND. With no requests, stay in IDLE.
- **SEND:** `tx_send=1` for exactly this cycle. Clear the counter, go to WAIT.
- **WAIT:** the counter runs 0..N-1, with `N = FRAME_BITS*CPB + GUARD_CYCLES`. `FRAME_BITS` is 10 when `tx_parity_type==0`, otherwise 11. At N-1, go to DONE.
- **DONE:** `ack[grant_id]=1`, `last<=grant_id`, go to IDLE.
- **Request handling:**
  - IDLE never grants in the cycle `ack` is high.
  - A request dropped after grant does not abort the frame; `ack` is still issued.
  - Requests arriving during SEND/WAIT/DONE wait for IDLE.
- **Data/parity stability:** `tx_data` and `tx_parity_type` change only on a grant. They stay stable from SEND through DONE.
- **Counter:** 32-bit, compared against N computed at elaboration for both parity cases.
- **Reset values:**
  - `rst` in any state gives state IDLE, `tx_send=0`, `ack=0`, `busy=0`, `tx_data=0`, `tx_parity_type=0`, `grant_id=0`.
  - `last=NUM_REQ-1`, so client 0 has first priority.
- **Reset mid-frame:** it does not stop `transmitter`, which has its own reset. The integrator resets both together.

## Timing
- Request sampled in IDLE at cycle t:
  - cycle t+1: SEND, `tx_send=1`, `tx_data` valid.
  - t+2..t+1+N: WAIT.
  - t+2+N: DONE, `ack` high.
  - t+3+N: IDLE, earliest next grant.
- `transmitter` returns to its idle state at t+2+FRAME_BITS*CPB. A guard of at least 2 cycles guarantees it has idled before the next `tx_send`.
- `tx_send` is never high on two consecutive cycles.
- Back-to-back grant period: N+3 cycles.

## Structure
- Package `uart_pkg`:
  - state encodings;
  - parity codes (NONE=0, ODD=1, EVEN=2);
  - `FRAME_BITS_NOPAR=10`, `FRAME_BITS_PAR=11`;
  - function `cpb(clk_freq, baud)`.
- Sub-module `rr_picker`: combinational round-robin search. Inputs `req` and `last`; outputs `valid` and `idx`.
- `transmitter` is instantiated one level up, not inside this block.

## Test plan
Benches use `CLK_FREQ=1000`, `BAUD=100` (CPB=10) and `GUARD_CYCLES=4`, so N=104 without parity and 114 with parity.
1. Single request: `req=0001`, byte 0xA5, parity 0. Required: `tx_send` for one cycle at t+1 with `tx_data=0xA5`, `ack=0001` at t+106, and the serial line decodes 0xA5.
2. All four requesting (bytes 0x10, 0x21, 0x32, 0x43) and held until ack. Required: grants in order 0,1,2,3, `ack` pulses 107 cycles apart, one `tx_send` per frame.
3. Client 2 re-requests immediately after its ack while client 3 is waiting. Required: client 3 is served before client 2.
4. `parity_sel=1` with byte 0x07, then `parity_sel=3`. Required: the first frame has a parity bit of 0 and `ack` at t+116; the second frame has `tx_parity_type=0` and `ack` at t+106.
5. `rst` asserted mid-WAIT. Required: next cycle state is IDLE with `busy=0`, `ack=0`, `tx_send=0`. The pending request is re-granted 1 cycle after `rst` falls, to client 0 first.
6. Client drops `req` during WAIT. Required: the frame completes and `ack` is still pulsed at t+106.
